// File: rtl/prim_reqack_arbiter_if.sv
// Handshake bundle between source-domain requesters, the arbiter and the SRC side of a req/ack CDC channel.
// Latency: none; this is wiring only.
// Backpressure: none here; the arbiter holds chan_req_o until chan_ack_i returns.
//
// Signal summary (directions as seen from the arbiter, i.e. the master modport):
//   req_i[NumReq]                  request level per requester
//   data_i[NumReq*DataWidth]       payload per requester; requester i owns slice i
//   ack_o[NumReq]                  one-cycle completion pulse to the granted requester
//   chan_req_o / chan_ack_i        request and ack on the synchronizer SRC side
//   chan_data_o / chan_idx_o       latched payload and grant index
//   busy_o / err_o                 transfer outstanding / sticky protocol error
interface prim_reqack_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32
);
  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [NumReq-1:0]           req_i;
  logic [NumReq*DataWidth-1:0] data_i;
  logic [NumReq-1:0]           ack_o;
  logic                        chan_req_o;
  logic                        chan_ack_i;
  logic [DataWidth-1:0]        chan_data_o;
  logic [IdxWidth-1:0]         chan_idx_o;
  logic                        busy_o;
  logic                        err_o;

  modport master (
    input  req_i, data_i, chan_ack_i,
    output ack_o, chan_req_o, chan_data_o, chan_idx_o, busy_o, err_o
  );

  modport slave (
    output req_i, data_i, chan_ack_i,
    input  ack_o, chan_req_o, chan_data_o, chan_idx_o, busy_o, err_o
  );
endinterface

// File: rtl/prim_reqack_arbiter.sv
// Round-robin arbiter that shares one REQ/ACK CDC channel among NumReq source-domain requesters.
// Latency: a request in cycle t drives chan_req_o in cycle t+1. After an ACK in cycle a, the next chan_req_o can appear in cycle a+2.
// Backpressure: one transfer is outstanding at a time. Other requesters wait, and the granted one holds req_i until its ack_o pulse.
//
// Ports: clk_i, rst_i (synchronous, active-high) and bus (prim_reqack_arbiter_if.master).
// bus carries the request and payload vectors, the ack pulses, the channel signals, busy_o and err_o.
module prim_reqack_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  prim_reqack_arbiter_if.master bus
);
  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, state_nxt;
  logic [IdxWidth-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IdxWidth-1:0]  chan_idx, chan_idx_nxt;
  logic [DataWidth-1:0] chan_data, chan_data_nxt;
  logic                 err, err_nxt;
  logic [NumReq-1:0]    ack;
  logic [IdxWidth-1:0]  winner;
  logic                 found;
  int                   j;

  // First set request at or above rr_ptr, wrapping modulo NumReq.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NumReq; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NumReq) j = j - NumReq;
      if (!found && bus.req_i[j]) begin
        found  = 1'b1;
        winner = IdxWidth'(j);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    chan_idx_nxt  = chan_idx;
    chan_data_nxt = chan_data;
    err_nxt       = err;
    ack           = '0;
    case (state)
      IDLE: begin
        // The channel only expects an ACK for an outstanding request.
        if (bus.chan_ack_i) err_nxt = 1'b1;
        if (found) begin
          chan_idx_nxt  = winner;
          chan_data_nxt = bus.data_i[int'(winner)*DataWidth +: DataWidth];
          state_nxt     = XFER;
        end
      end
      XFER: begin
        // A request already in flight cannot be retracted, so a dropped req only flags an error.
        if (!bus.req_i[chan_idx]) err_nxt = 1'b1;
        if (bus.chan_ack_i) begin
          ack[chan_idx] = 1'b1;
          // The served requester drops to lowest priority. NumReq=1 keeps the pointer at 0.
          rr_ptr_nxt    = (int'(chan_idx) + 1 >= NumReq) ? '0 : chan_idx + 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      chan_idx  <= '0;
      chan_data <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      chan_idx  <= chan_idx_nxt;
      chan_data <= chan_data_nxt;
      err       <= err_nxt;
    end
  end

  assign bus.chan_req_o  = (state == XFER);
  assign bus.busy_o      = (state == XFER);
  assign bus.chan_idx_o  = chan_idx;
  assign bus.chan_data_o = chan_data;
  assign bus.err_o       = err;
  assign bus.ack_o       = ack;

`ifndef SYNTHESIS
  // A reset in the following cycle is the only legal way to drop a request without an ACK.
  a_req_hold: assert property (@(posedge clk_i)
    (bus.chan_req_o && !bus.chan_ack_i && !rst_i) |=>
      (rst_i || (bus.chan_req_o && $stable(bus.chan_data_o) && $stable(bus.chan_idx_o))));
  a_ack_onehot: assert property (@(posedge clk_i) $onehot0(bus.ack_o));
`endif
endmodule

// File: tb/tb_prim_reqack_arbiter.sv
module tb_prim_reqack_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  prim_reqack_arbiter_if #(.NumReq(4), .DataWidth(32)) bus ();

  prim_reqack_arbiter #(.NumReq(4), .DataWidth(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Step past the next rising edge; inputs driven and outputs read here are clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_i      = '0;
    bus.chan_ack_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.data_i = '0;
    do_reset();
    checks++; if (bus.chan_req_o !== 1'b0) begin failures++; $display("FAIL reset_chan_req got=%b exp=0", bus.chan_req_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.ack_o !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", bus.ack_o); end
    checks++; if (bus.chan_data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.chan_data_o); end
    checks++; if (bus.chan_idx_o !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.chan_idx_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
  endtask

  task automatic test_single();
    do_reset();
    bus.data_i[2*32 +: 32] = 32'hDEAD_BEEF;
    bus.req_i = 4'b0100;
    tick();
    checks++; if (bus.chan_req_o !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", bus.chan_req_o); end
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy_o); end
    checks++; if (bus.chan_idx_o !== 2'd2) begin failures++; $display("FAIL single_idx got=%0d exp=2", bus.chan_idx_o); end
    checks++; if (bus.chan_data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", bus.chan_data_o); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.chan_req_o !== 1'b1 || bus.ack_o !== 4'b0000) begin failures++; $display("FAIL single_wait%0d req=%b ack=%b exp req=1 ack=0000", c, bus.chan_req_o, bus.ack_o); end
    end
    tick();
    bus.chan_ack_i = 1'b1;
    #1;
    checks++; if (bus.ack_o !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", bus.ack_o); end
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0000;
    #1;
    checks++; if (bus.ack_o !== 4'b0000) begin failures++; $display("FAIL single_ack_len got=%b exp=0000", bus.ack_o); end
    checks++; if (bus.chan_req_o !== 1'b0) begin failures++; $display("FAIL single_req_drop got=%b exp=0", bus.chan_req_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", bus.err_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_idx;
    logic [3:0] exp_ack;
    do_reset();
    for (int i = 0; i < 4; i++) bus.data_i[i*32 +: 32] = 32'h1000_0000 + i;
    bus.req_i = 4'b1111;
    tick();
    for (int n = 0; n < 6; n++) begin
      exp_idx = 2'(n % 4);
      exp_ack = 4'b0001 << exp_idx;
      checks++; if (bus.chan_req_o !== 1'b1 || bus.chan_idx_o !== exp_idx) begin failures++; $display("FAIL rr_grant%0d req=%b idx=%0d exp req=1 idx=%0d", n, bus.chan_req_o, bus.chan_idx_o, exp_idx); end
      checks++; if (bus.chan_data_o !== 32'h1000_0000 + 32'(exp_idx)) begin failures++; $display("FAIL rr_data%0d got=%h exp=%h", n, bus.chan_data_o, 32'h1000_0000 + 32'(exp_idx)); end
      tick(); tick(); tick();
      bus.chan_ack_i = 1'b1;
      #1;
      checks++; if (bus.ack_o !== exp_ack) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", n, bus.ack_o, exp_ack); end
      tick();
      bus.chan_ack_i = 1'b0;
      checks++; if (bus.chan_req_o !== 1'b0) begin failures++; $display("FAIL rr_gap%0d got=%b exp=0", n, bus.chan_req_o); end
      tick();
    end
    bus.req_i = 4'b0000;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    bus.req_i = 4'b0100;
    tick();
    bus.chan_ack_i = 1'b1;
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0011;
    tick();
    checks++; if (bus.chan_idx_o !== 2'd0 || bus.chan_req_o !== 1'b1) begin failures++; $display("FAIL wrap_idx got=%0d req=%b exp idx=0 req=1", bus.chan_idx_o, bus.chan_req_o); end
    bus.chan_ack_i = 1'b1;
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0010;
    tick();
    checks++; if (bus.chan_idx_o !== 2'd1 || bus.chan_req_o !== 1'b1) begin failures++; $display("FAIL skip_idx got=%0d req=%b exp idx=1 req=1", bus.chan_idx_o, bus.chan_req_o); end
    bus.chan_ack_i = 1'b1;
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0000;
    tick();
  endtask

  task automatic test_data_stability();
    do_reset();
    bus.data_i[0 +: 32] = 32'hA5A5_0001;
    bus.req_i = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      bus.data_i[0 +: 32] = 32'h0BAD_0000 + c;
      tick();
      checks++; if (bus.chan_data_o !== 32'hA5A5_0001) begin failures++; $display("FAIL stable_data%0d got=%h exp=a5a50001", c, bus.chan_data_o); end
    end
    bus.chan_ack_i = 1'b1;
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0000;
    tick();
  endtask

  task automatic test_drop_violation();
    do_reset();
    bus.req_i = 4'b1000;
    tick();
    bus.req_i = 4'b0000;
    tick();
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL drop_err got=%b exp=1", bus.err_o); end
    checks++; if (bus.chan_req_o !== 1'b1) begin failures++; $display("FAIL drop_req got=%b exp=1", bus.chan_req_o); end
    tick();
    bus.chan_ack_i = 1'b1;
    #1;
    checks++; if (bus.ack_o !== 4'b1000) begin failures++; $display("FAIL drop_ack got=%b exp=1000", bus.ack_o); end
    tick();
    bus.chan_ack_i = 1'b0;
    checks++; if (bus.chan_req_o !== 1'b0 || bus.err_o !== 1'b1) begin failures++; $display("FAIL drop_after req=%b err=%b exp req=0 err=1", bus.chan_req_o, bus.err_o); end
  endtask

  task automatic test_ack_in_idle();
    do_reset();
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL idle_err_pre got=%b exp=0", bus.err_o); end
    bus.chan_ack_i = 1'b1;
    #1;
    checks++; if (bus.ack_o !== 4'b0000) begin failures++; $display("FAIL idle_ack got=%b exp=0000", bus.ack_o); end
    tick();
    bus.chan_ack_i = 1'b0;
    checks++; if (bus.err_o !== 1'b1 || bus.chan_req_o !== 1'b0) begin failures++; $display("FAIL idle_err err=%b req=%b exp err=1 req=0", bus.err_o, bus.chan_req_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.chan_ack_i = 1'b1;
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0010;
    tick();
    bus.chan_ack_i = 1'b1;
    tick();
    bus.chan_ack_i = 1'b0;
    bus.req_i      = 4'b0100;
    tick();
    checks++; if (bus.chan_idx_o !== 2'd2 || bus.err_o !== 1'b1) begin failures++; $display("FAIL mid_setup idx=%0d err=%b exp idx=2 err=1", bus.chan_idx_o, bus.err_o); end
    rst       = 1'b1;
    bus.req_i = 4'b1111;
    tick();
    checks++; if (bus.chan_req_o !== 1'b0 || bus.ack_o !== 4'b0000 || bus.err_o !== 1'b0) begin failures++; $display("FAIL mid_reset req=%b ack=%b err=%b exp 0 0000 0", bus.chan_req_o, bus.ack_o, bus.err_o); end
    rst = 1'b0;
    tick();
    checks++; if (bus.chan_req_o !== 1'b1 || bus.chan_idx_o !== 2'd0) begin failures++; $display("FAIL mid_first_grant req=%b idx=%0d exp req=1 idx=0", bus.chan_req_o, bus.chan_idx_o); end
    bus.req_i = 4'b0000;
  endtask

  initial begin
    bus.req_i      = '0;
    bus.data_i     = '0;
    bus.chan_ack_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_data_stability();
    test_drop_violation();
    test_ack_in_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prim_reqack_arbiter.md
Name: prim_reqack_arbiter

Overview:
- Shares one REQ/ACK clock-domain-crossing handshake channel among NumReq requesters in the source clock domain.
- Selects requesters round-robin and drives one channel request at a time.
- Latches the winner's payload and index so both stay stable on the crossing for the whole transfer.
- Returns the channel ACK as a one-cycle pulse to the winning requester only.
- Sits between source-domain clients and the SRC side of the req/ack synchronizer.

Parameters:
- NumReq, 4, number of requesters; legal range 1..32.
- DataWidth, 32, width of the per-requester payload forwarded with the request.
- IdxWidth, derived as max(1, $clog2(NumReq)), width of the grant index. Not for override.

Ports:
- clk_i  in  1  clock; source domain of the synchronizer.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  NumReq  per-requester request level.
- data_i  in  NumReq*DataWidth  per-requester payload; requester i owns slice i.
- ack_o  out  NumReq  one-cycle completion pulse to the granted requester.
- chan_req_o  out  1  request to the synchronizer SRC side.
- chan_ack_i  in  1  one-cycle ACK pulse from the synchronizer SRC side.
- chan_data_o  out  DataWidth  latched payload; stable while chan_req_o=1.
- chan_idx_o  out  IdxWidth  latched grant index; stable while chan_req_o=1.
- busy_o  out  1  high while a transfer is outstanding (equals chan_req_o).
- err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_i=1 at a clk_i edge) values:
  - FSM state = IDLE, rr_ptr=0.
  - chan_req_o=0, busy_o=0, ack_o=0, chan_data_o=0, chan_idx_o=0, err_o=0.
- Reset also abandons any outstanding transfer. Integration rule: the DST side of the synchronizer must be reset in the same window.
- FSM states: IDLE, XFER.
- IDLE behaviour:
  - chan_req_o=0.
  - If any bit of req_i is set, pick the winner: the first set bit searching upward from rr_ptr, wrapping modulo NumReq.
  - On that edge, latch chan_idx_o=winner and chan_data_o=data_i[winner], then go to XFER.
  - If no request, stay in IDLE; latched outputs hold their values.
- XFER behaviour:
  - chan_req_o=1.
  - chan_data_o and chan_idx_o are frozen.
  - Other requesters are ignored.
  - On chan_ack_i=1, drive ack_o[chan_idx_o]=1 combinationally in that same cycle, set rr_ptr=(chan_idx_o+1) mod NumReq, and go to IDLE.
- Latency and throughput:
  - req_i rises in cycle t → chan_req_o=1 in cycle t+1.
  - ACK in cycle a → earliest next chan_req_o in cycle a+2, because IDLE lasts one cycle. chan_req_o therefore always deasserts after an ACK.
  - Maximum rate is one transfer per (channel round-trip + 2) cycles.
- Requester rules:
  - Before grant, a requester may drop req_i without effect.
  - After grant, the requester must hold req_i until its ack_o pulse.
  - If the granted req_i[chan_idx_o] drops while in XFER: set err_o, keep chan_req_o=1 (the channel cannot retract a request), and still pulse ack_o on completion.
- The winner's req_i must be held through its ack_o cycle. Any requester still asserting req_i one cycle after its ack_o is treated as a new request.
- Fairness: after a requester is served it has lowest priority. With all NumReq requesting, grants cycle 0,1,…,NumReq-1,0…
- ACK outside XFER: chan_ack_i=1 while in IDLE sets err_o and is otherwise ignored; no ack_o pulse.
- err_o is sticky until rst_i.
- ack_o is one-hot or zero in every cycle.
- NumReq=1: rr_ptr is held at 0 and chan_idx_o=0 always.
- Assertions:
  - chan_req_o never falls without chan_ack_i in the same cycle.
  - chan_data_o and chan_idx_o are $stable while chan_req_o=1.
  - $onehot0(ack_o).

Test Plan:
- Single request: after reset, req_i=4'b0100 with data_i[2]=32'hDEAD_BEEF. Expect chan_req_o=1 next cycle, chan_idx_o=2, chan_data_o=32'hDEAD_BEEF. Pulse chan_ack_i 6 cycles later → ack_o=4'b0100 for exactly 1 cycle, chan_req_o=0 in the following cycle.
- Round-robin: req_i=4'b1111 held, each channel request ACKed after 3 cycles. Expect grant sequence 0,1,2,3,0,1; chan_req_o low for exactly 1 cycle between transfers.
- Pointer wrap and skip: rr_ptr=3 after serving idx 2, req_i=4'b0011 → grant idx 0. Next grant, with only bit 1 still set → idx 1.
- Data stability: change data_i[winner] every cycle during XFER → chan_data_o unchanged until ACK; stability assertion never fires.
- Violations:
  - Granted requester drops req_i mid-XFER → err_o=1 next cycle, chan_req_o stays 1, ack_o still pulses on ACK.
  - Separately, chan_ack_i pulse in IDLE → err_o=1, ack_o=0.
- Reset mid-transfer: assert rst_i during XFER → next cycle chan_req_o=0, ack_o=0, err_o=0. First grant after reset is idx 0, given req_i=4'b1111.
